imem_loader: RTL and testbench

Byte-stream writer for the 64-word instruction memory that the single-cycle CPU fetches from. Accepts a framed program over a valid/ready byte interface, assembles little-endian 32-bit words and issues one write per word to the instruction RAM write port. Holds the CPU in reset until a complete, accepted load has finished, then releases it so fetch starts at the reset PC with the new image.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the imem_loader.
// The loader takes the slave modport; the stream source / RAM side takes master.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the CPU instruction RAM; holds the CPU in reset until a load completes.
// Optional trailing checksum byte is compiled in with `define IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_rst,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOADER_CSUM_EN
    , S_CSUM,
    S_ERR
`endif
  } state_e;

  // Header value 0 stands for a full RAM image.
  localparam logic [AW-1:0] LAST_FULL = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] last_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    sum_q;
`endif

  // Every output is a decode of the state register or a plain register, so
  // in_valid/in_data never reach an output combinationally.
  assign bus.in_ready  = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CSUM_EN
                         || (state_q == S_CSUM)
`endif
                         ;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE)
`ifdef IMEM_LOADER_CSUM_EN
                         || (state_q == S_CSUM)
`endif
                         ;
  assign done          = (state_q == S_DONE);
  assign cpu_rst       = (state_q != S_DONE);
`ifdef IMEM_LOADER_CSUM_EN
  assign err           = (state_q == S_ERR);
`else
  assign err           = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      byte_idx_q <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_HDR;
        end

        S_HDR: begin
`ifdef IMEM_LOADER_CSUM_EN
          sum_q <= '0;
`endif
          if (bus.in_valid) begin
            last_q     <= (bus.in_data[AW-1:0] == '0) ? LAST_FULL
                                                      : bus.in_data[AW-1:0] - AW'(1);
            addr_q     <= '0;
            byte_idx_q <= '0;
            state_q    <= S_DATA;
          end
        end

        S_DATA: begin
          if (bus.in_valid) begin
            wdata_q[{byte_idx_q, 3'b000} +: 8] <= bus.in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q      <= sum_q + bus.in_data;
`endif
            if (byte_idx_q == 2'd3) state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Wraps to 0 after a full image; no extra write follows.
          addr_q <= addr_q + AW'(1);
          if (addr_q == last_q) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_q <= S_CSUM;
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_DATA;
          end
        end

`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (bus.in_valid) state_q <= (bus.in_data == sum_q) ? S_DONE : S_ERR;
        end

        S_ERR: begin
          if (start) state_q <= S_HDR;
        end
`endif

        S_DONE: begin
          if (start) state_q <= S_HDR;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of short loads plus directed corner sequences.
// Follows IMEM_LOADER_CSUM_EN so the same bench covers both builds.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef IMEM_LOADER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic cpu_rst, busy, done, err;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int rdy_viol = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor and in_ready/mem_we relationship while a load is running.
  always @(negedge clk) begin
    if (bus.mem_we) wq.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
    if (busy && (bus.in_ready == bus.mem_we)) rdy_viol++;
  end

  typedef struct {
    logic [7:0]  hdr;
    int          nw;
    logic [7:0]  b [8];
    logic [7:0]  cs;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: in_ready never rose for byte %h", b);
    end
    tick();
  endtask

  task automatic wait_end(input int s, output int lat);
    bit got = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (done || err) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    lat = cyc - s;
    if (!got) begin
      nchk++;
      nerr++;
      $display("FAIL wait_end: got no DONE/ERR, expected one within 1000 cycles");
    end
  endtask

  task automatic feed_frame(input logic [7:0] hdr, input logic [7:0] data[$], input logic [7:0] cs);
    send_byte(hdr);
    foreach (data[i]) send_byte(data[i]);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(cs);
`endif
    bus.in_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] hdr, input logic [7:0] data[$], input logic [7:0] cs,
                          output int lat);
    int s;
    s = cyc;
    pulse_start();
    feed_frame(hdr, data, cs);
    wait_end(s, lat);
  endtask

  vec_t vecs [4];
  logic [7:0] q[$];
  int lat, s, bad;

  initial begin
    // Checksums are the mod-256 sum of the data bytes of each row.
    vecs[0] = '{8'h02, 2, '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00},
                8'hC0, 32'h0000_0513, 32'h0010_0593};
    vecs[1] = '{8'h01, 1, '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h38, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{8'h01, 1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
                8'hFC, 32'hFFFF_FFFF, 32'h0};
    vecs[3] = '{8'h02, 2, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h80},
                8'h8A, 32'h0403_0201, 32'h8000_0000};

    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_cpu_rst",  cpu_rst,       1);
    check("rst_in_ready", bus.in_ready,  0);
    check("rst_mem_we",   bus.mem_we,    0);
    check("rst_mem_addr", bus.mem_addr,  0);
    check("rst_wdata",    bus.mem_wdata, 0);
    check("rst_busy",     busy,          0);
    check("rst_done",     done,          0);
    check("rst_err",      err,           0);

    // rst and start together: rst wins, loader stays idle.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_idle", bus.in_ready, 0);

    // Table of short loads, run back to back (each start after the first lands in DONE).
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      q.delete();
      for (int j = 0; j < 4 * vecs[i].nw; j++) q.push_back(vecs[i].b[j]);
      do_frame(vecs[i].hdr, q, vecs[i].cs, lat);
      check($sformatf("v%0d_latency", i), lat, 2 + 5 * vecs[i].nw + CS);
      check($sformatf("v%0d_nwrites", i), wq.size(), vecs[i].nw);
      if (wq.size() >= 1) begin
        check($sformatf("v%0d_addr0", i), wq[0].addr, 0);
        check($sformatf("v%0d_data0", i), wq[0].data, vecs[i].w0);
      end
      if (wq.size() >= 2) begin
        check($sformatf("v%0d_addr1", i), wq[1].addr, 1);
        check($sformatf("v%0d_data1", i), wq[1].data, vecs[i].w1);
      end
      check($sformatf("v%0d_done", i),    done,    1);
      check($sformatf("v%0d_err", i),     err,     0);
      check($sformatf("v%0d_cpu_rst", i), cpu_rst, 0);
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum ends in ERR with the CPU held in reset.
    q.delete();
    for (int j = 0; j < 8; j++) q.push_back(vecs[0].b[j]);
    do_frame(8'h02, q, 8'h00, lat);
    check("bad_cs_err",     err,     1);
    check("bad_cs_done",    done,    0);
    check("bad_cs_cpu_rst", cpu_rst, 1);
    repeat (5) tick();
    check("bad_cs_hold",    cpu_rst, 1);
`endif

    // Start from DONE (or ERR): flags clear and the CPU goes back into reset at once.
    q.delete();
    for (int j = 0; j < 8; j++) q.push_back(vecs[0].b[j]);
    do_frame(8'h02, q, 8'hC0, lat);
    check("restart_pre_done", done, 1);
    pulse_start();
    check("restart_done",     done,         0);
    check("restart_err",      err,          0);
    check("restart_cpu_rst",  cpu_rst,      1);
    check("restart_in_ready", bus.in_ready, 1);

    // start pulsed mid-word is ignored; load finishes with normal timing.
    wq.delete();
    send_byte(8'h01);
    send_byte(8'h11);
    start = 1'b1;
    send_byte(8'h22);
    start = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'hAA);
`endif
    bus.in_valid = 1'b0;
    wait_end(cyc, lat);
    check("mid_start_nwrites", wq.size(), 1);
    if (wq.size() >= 1) check("mid_start_data", wq[0].data, 32'h4433_2211);
    check("mid_start_done", done, 1);

    // Full image: header 0 means 64 words, every byte of word w equals w.
    wq.delete();
    q.delete();
    for (int w = 0; w < DEPTH; w++)
      for (int j = 0; j < 4; j++) q.push_back(8'(w));
    do_frame(8'h00, q, 8'h80, lat);
    check("full_latency", lat, 2 + 5 * DEPTH + CS);
    check("full_nwrites", wq.size(), DEPTH);
    bad = 0;
    foreach (wq[i])
      if (wq[i].addr !== AW'(i) || wq[i].data !== {4{8'(i)}}) bad++;
    check("full_bad_writes", bad, 0);
    repeat (10) tick();
    check("full_no_extra_write", wq.size(), DEPTH);
    check("full_done",     done,         1);
    check("full_addr_wrap", bus.mem_addr, 0);

    // in_valid toggled every other cycle; in_ready drops only in the WRITE cycle.
    wq.delete();
    rdy_viol = 0;
    s = cyc;
    pulse_start();
    q.delete();
    q.push_back(8'h01);
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    q.push_back(8'hCC);
    q.push_back(8'hDD);
`ifdef IMEM_LOADER_CSUM_EN
    q.push_back(8'h0E);
`endif
    foreach (q[i]) begin
      bus.in_valid = 1'b0;
      tick();
      send_byte(q[i]);
    end
    bus.in_valid = 1'b0;
    wait_end(s, lat);
    check("gap_nwrites", wq.size(), 1);
    if (wq.size() >= 1) check("gap_data", wq[0].data, 32'hDDCC_BBAA);
    check("gap_ready_only_low_in_write", rdy_viol, 0);
    check("gap_done", done, 1);

    // rst after 6 data bytes of a 2-word load: word 0 kept, word 1 never written.
    wq.delete();
    pulse_start();
    send_byte(8'h02);
    for (int j = 1; j <= 6; j++) send_byte(8'(j));
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_busy",     busy,          0);
    check("midrst_in_ready", bus.in_ready,  0);
    check("midrst_cpu_rst",  cpu_rst,       1);
    check("midrst_done",     done,          0);
    check("midrst_mem_we",   bus.mem_we,    0);
    check("midrst_addr",     bus.mem_addr,  0);
    check("midrst_wdata",    bus.mem_wdata, 0);
    repeat (8) tick();
    check("midrst_nwrites", wq.size(), 1);
    if (wq.size() >= 1) check("midrst_word0", wq[0].data, 32'h0403_0201);
    check("midrst_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
